// File: rtl/divide_block_m.sv
// Multi-cycle restoring divider sharing the datapath byte_op/word convention.
// Signed operands are divided as magnitudes and sign-corrected in one fixup cycle.
module divide_block_m #(
   parameter int unsigned WORD_SIZE = 16
) (
   input  logic                 clk,
   input  logic                 reset_n,
   input  logic                 start,
   input  logic                 byte_op,
   input  logic                 signed_op,
   input  logic [WORD_SIZE-1:0] src_a,
   input  logic [WORD_SIZE-1:0] src_b,
   output logic                 busy,
   output logic                 done,
   output logic [WORD_SIZE-1:0] quotient,
   output logic [WORD_SIZE-1:0] remainder,
   output logic                 div_zero,
   output logic                 ovf
);

   localparam int unsigned HALF_WORD = WORD_SIZE / 2;
   localparam int unsigned CW = $clog2(WORD_SIZE + 1);
   localparam logic [WORD_SIZE-1:0] HalfMask = {{HALF_WORD{1'b0}}, {HALF_WORD{1'b1}}};
   localparam logic [WORD_SIZE-1:0] MinHalf = HalfMask ^ (HalfMask >> 1);
   localparam logic [WORD_SIZE-1:0] MinWord = {1'b1, {(WORD_SIZE-1){1'b0}}};

   typedef enum logic [1:0] {StIdle, StIter, StFixup, StDone} state_t;

   state_t               state_q;
   logic [WORD_SIZE-1:0] acc_q, q_q, b_abs_q;
   logic [CW-1:0]        count_q;
   logic                 byte_q, signed_q, sign_a_q, sign_b_q;

   logic [WORD_SIZE-1:0] mask_in, a_in, b_in, a_abs_in, b_abs_in;
   logic                 sign_a_in, sign_b_in;
   logic [WORD_SIZE:0]   acc_sh;
   logic                 take;
   logic [WORD_SIZE-1:0] acc_next, mask_q, min_q, q_fix, r_fix;
   logic                 ovf_fix;

   always_comb begin
      mask_in   = byte_op ? HalfMask : '1;
      a_in      = src_a & mask_in;
      b_in      = src_b & mask_in;
      sign_a_in = signed_op & (byte_op ? src_a[HALF_WORD-1] : src_a[WORD_SIZE-1]);
      sign_b_in = signed_op & (byte_op ? src_b[HALF_WORD-1] : src_b[WORD_SIZE-1]);
      a_abs_in  = sign_a_in ? ((-a_in) & mask_in) : a_in;
      b_abs_in  = sign_b_in ? ((-b_in) & mask_in) : b_in;
   end

   // One restoring step; acc_sh needs an extra bit before the compare.
   always_comb begin
      acc_sh   = {acc_q, q_q[WORD_SIZE-1]};
      take     = (acc_sh >= {1'b0, b_abs_q});
      acc_next = take ? (acc_sh[WORD_SIZE-1:0] - b_abs_q) : acc_sh[WORD_SIZE-1:0];
   end

   // MIN / -1 falls out of the magnitude path as |q| = MIN, r = 0; only the flag is extra.
   always_comb begin
      mask_q  = byte_q ? HalfMask : '1;
      min_q   = byte_q ? MinHalf : MinWord;
      q_fix   = (sign_a_q ^ sign_b_q) ? ((-q_q) & mask_q) : q_q;
      r_fix   = sign_a_q ? ((-acc_q) & mask_q) : acc_q;
      ovf_fix = signed_q & sign_a_q & sign_b_q & (b_abs_q == WORD_SIZE'(1)) & (q_q == min_q);
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q   <= StIdle;
         acc_q     <= '0;
         q_q       <= '0;
         b_abs_q   <= '0;
         count_q   <= '0;
         byte_q    <= 1'b0;
         signed_q  <= 1'b0;
         sign_a_q  <= 1'b0;
         sign_b_q  <= 1'b0;
         busy      <= 1'b0;
         done      <= 1'b0;
         quotient  <= '0;
         remainder <= '0;
         div_zero  <= 1'b0;
         ovf       <= 1'b0;
      end else begin
         unique case (state_q)
            StIdle: begin
               if (start) begin
                  byte_q   <= byte_op;
                  signed_q <= signed_op;
                  sign_a_q <= sign_a_in;
                  sign_b_q <= sign_b_in;
                  b_abs_q  <= b_abs_in;
                  // Byte dividend sits in the top half so the shift-out bit is always the MSB.
                  q_q      <= byte_op ? (a_abs_in << HALF_WORD) : a_abs_in;
                  acc_q    <= '0;
                  count_q  <= byte_op ? CW'(HALF_WORD) : CW'(WORD_SIZE);
                  busy     <= 1'b1;
                  div_zero <= 1'b0;
                  ovf      <= 1'b0;
                  if (b_in == '0) begin
                     quotient  <= mask_in;
                     remainder <= a_in;
                     div_zero  <= 1'b1;
                     done      <= 1'b1;
                     state_q   <= StDone;
                  end else begin
                     state_q <= StIter;
                  end
               end
            end
            StIter: begin
               acc_q   <= acc_next;
               q_q     <= {q_q[WORD_SIZE-2:0], take};
               count_q <= count_q - CW'(1);
               if (count_q == CW'(1)) begin
                  state_q <= StFixup;
               end
            end
            StFixup: begin
               quotient  <= q_fix;
               remainder <= r_fix;
               ovf       <= ovf_fix;
               done      <= 1'b1;
               state_q   <= StDone;
            end
            StDone: begin
               done    <= 1'b0;
               busy    <= 1'b0;
               state_q <= StIdle;
            end
            default: state_q <= StIdle;
         endcase
      end
   end

endmodule

// File: tb/tb_divide_block_m.sv
// Randomized bench for divide_block_m against an integer-arithmetic reference model.
module tb_divide_block_m;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic        start = 1'b0;
   logic        byte_op = 1'b0;
   logic        signed_op = 1'b0;
   logic [15:0] src_a = '0;
   logic [15:0] src_b = '0;
   logic        busy, done, div_zero, ovf;
   logic [15:0] quotient, remainder;

   int errors = 0;
   int checks = 0;

   divide_block_m #(.WORD_SIZE(16)) dut (
      .clk       (clk),
      .reset_n   (reset_n),
      .start     (start),
      .byte_op   (byte_op),
      .signed_op (signed_op),
      .src_a     (src_a),
      .src_b     (src_b),
      .busy      (busy),
      .done      (done),
      .quotient  (quotient),
      .remainder (remainder),
      .div_zero  (div_zero),
      .ovf       (ovf)
   );

   always #5 clk = ~clk;

   task automatic model(input logic [15:0] a, input logic [15:0] b, input logic bo,
                        input logic so, output logic [15:0] eq, output logic [15:0] er,
                        output logic edz, output logic eovf, output int elat);
      int n, mask, av, bv, sa, sb, qi, ri;
      n    = bo ? 8 : 16;
      mask = (1 << n) - 1;
      av   = int'(a) & mask;
      bv   = int'(b) & mask;
      sa   = (so && ((av >> (n - 1)) & 1) == 1) ? av - (1 << n) : av;
      sb   = (so && ((bv >> (n - 1)) & 1) == 1) ? bv - (1 << n) : bv;
      edz  = 1'b0;
      eovf = 1'b0;
      elat = n + 2;
      if (bv == 0) begin
         qi = mask; ri = av; edz = 1'b1; elat = 1;
      end else if (so) begin
         if (sa == -(1 << (n - 1)) && sb == -1) begin
            qi = 1 << (n - 1); ri = 0; eovf = 1'b1;
         end else begin
            qi = sa / sb; ri = sa % sb;
         end
      end else begin
         qi = av / bv; ri = av % bv;
      end
      eq = 16'(qi & mask);
      er = 16'(ri & mask);
   endtask

   task automatic run_and_check(input string name, input logic [15:0] a, input logic [15:0] b,
                                input logic bo, input logic so, input int poke_at);
      logic [15:0] eq, er;
      logic        edz, eovf;
      int          elat, edges;
      bit          busy_ok;
      model(a, b, bo, so, eq, er, edz, eovf, elat);
      src_a = a; src_b = b; byte_op = bo; signed_op = so; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      src_a = 16'($urandom); src_b = 16'($urandom);
      byte_op = 1'($urandom); signed_op = 1'($urandom);
      edges = 1;
      busy_ok = 1'b1;
      while (!done && edges < 40) begin
         if (!busy) busy_ok = 1'b0;
         if (edges == poke_at) start = 1'b1;
         @(posedge clk); #1;
         start = 1'b0;
         edges++;
      end
      checks++;
      if (edges !== elat)
         begin errors++; $display("FAIL %s latency: got %0d edges want %0d", name, edges, elat); end
      checks++;
      if (!busy_ok || busy !== 1'b1)
         begin errors++; $display("FAIL %s busy: low before done ended (busy=%b)", name, busy); end
      checks++;
      if (quotient !== eq)
         begin errors++; $display("FAIL %s quotient: got %h want %h", name, quotient, eq); end
      checks++;
      if (remainder !== er)
         begin errors++; $display("FAIL %s remainder: got %h want %h", name, remainder, er); end
      checks++;
      if (div_zero !== edz || ovf !== eovf)
         begin
            errors++;
            $display("FAIL %s flags: got dz=%b ovf=%b want dz=%b ovf=%b", name, div_zero, ovf,
                     edz, eovf);
         end
      @(posedge clk); #1;
      checks++;
      if (done !== 1'b0 || busy !== 1'b0 || quotient !== eq || remainder !== er)
         begin
            errors++;
            $display("FAIL %s after_done: got done=%b busy=%b q=%h r=%h want 0 0 %h %h", name,
                     done, busy, quotient, remainder, eq, er);
         end
   endtask

   task automatic test_reset();
      #1;
      checks++;
      if ({busy, done, div_zero, ovf, quotient, remainder} !== '0)
         begin errors++; $display("FAIL reset_outputs: got q=%h r=%h busy=%b done=%b want all 0",
                                  quotient, remainder, busy, done); end
      @(negedge clk) reset_n = 1'b1;
      @(posedge clk); #1;
      checks++;
      if (busy !== 1'b0 || done !== 1'b0)
         begin errors++; $display("FAIL reset_idle: got busy=%b done=%b want 0 0", busy, done); end
   endtask

   task automatic test_directed();
      run_and_check("u_word_100_7", 16'd100, 16'd7, 1'b0, 1'b0, 0);
      run_and_check("s_word_m100_7", 16'hFF9C, 16'd7, 1'b0, 1'b1, 0);
      run_and_check("s_byte_min_m1", 16'hAB80, 16'h12FF, 1'b1, 1'b1, 0);
      run_and_check("div_zero", 16'h1234, 16'h0000, 1'b0, 1'b0, 0);
      run_and_check("u_ffff_1", 16'hFFFF, 16'h0001, 1'b0, 1'b0, 0);
      run_and_check("u_0_3", 16'h0000, 16'h0003, 1'b0, 1'b0, 0);
      run_and_check("s_word_min_m1", 16'h8000, 16'hFFFF, 1'b0, 1'b1, 0);
      run_and_check("byte_div_zero_hi", 16'h5A3C, 16'h7700, 1'b1, 1'b1, 0);
   endtask

   task automatic test_start_ignored();
      run_and_check("start_in_iter", 16'd100, 16'd7, 1'b0, 1'b0, 5);
   endtask

   task automatic test_random();
      logic [15:0] a, b;
      logic        bo, so;
      int          sel;
      for (int i = 0; i < 150; i++) begin
         a   = 16'($urandom);
         b   = 16'($urandom);
         bo  = 1'($urandom);
         so  = 1'($urandom);
         sel = $urandom_range(0, 9);
         if (sel == 0) b = bo ? {b[15:8], 8'h00} : 16'h0000;
         else if (sel == 1) begin
            so = 1'b1;
            a  = bo ? {a[15:8], 8'h80} : 16'h8000;
            b  = bo ? {b[15:8], 8'hFF} : 16'hFFFF;
         end else if (sel < 5) b = b & 16'h000F;
         run_and_check("random", a, b, bo, so, 0);
      end
   endtask

   task automatic test_abort_reset();
      int edges;
      bit saw_done;
      src_a = 16'd100; src_b = 16'd7; byte_op = 1'b0; signed_op = 1'b0; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      for (edges = 1; edges < 9; edges++) begin
         @(posedge clk); #1;
      end
      reset_n = 1'b0;
      #1;
      checks++;
      if ({busy, done, div_zero, ovf, quotient, remainder} !== '0)
         begin errors++; $display("FAIL abort_clear: got q=%h r=%h busy=%b done=%b want all 0",
                                  quotient, remainder, busy, done); end
      saw_done = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(posedge clk); #1;
         if (done) saw_done = 1'b1;
      end
      @(negedge clk) reset_n = 1'b1;
      for (int i = 0; i < 20; i++) begin
         @(posedge clk); #1;
         if (done || busy) saw_done = 1'b1;
      end
      checks++;
      if (saw_done)
         begin errors++; $display("FAIL abort_no_done: got done/busy activity want none"); end
      run_and_check("after_abort", 16'hFF9C, 16'd7, 1'b0, 1'b1, 0);
   endtask

   task automatic test_back_to_back();
      int edges;
      src_a = 16'd200; src_b = 16'd9; byte_op = 1'b0; signed_op = 1'b0; start = 1'b1;
      @(posedge clk); #1;
      edges = 1;
      while (!done && edges < 40) begin
         @(posedge clk); #1;
         edges++;
      end
      checks++;
      if (done !== 1'b1 || quotient !== 16'd22 || remainder !== 16'd2)
         begin errors++; $display("FAIL b2b_first: got done=%b q=%h r=%h want 1 0016 0002",
                                  done, quotient, remainder); end
      src_a = 16'h0033; src_b = 16'h0005; byte_op = 1'b1;
      @(posedge clk); #1;
      checks++;
      if (busy !== 1'b0 || done !== 1'b0)
         begin errors++; $display("FAIL b2b_gap: got busy=%b done=%b want 0 0", busy, done); end
      @(posedge clk); #1;
      start = 1'b0;
      checks++;
      if (busy !== 1'b1)
         begin errors++; $display("FAIL b2b_accept: got busy=%b want 1", busy); end
      edges = 1;
      while (!done && edges < 40) begin
         @(posedge clk); #1;
         edges++;
      end
      checks++;
      if (edges !== 10 || quotient !== 16'h000A || remainder !== 16'h0001)
         begin errors++; $display("FAIL b2b_second: got edges=%0d q=%h r=%h want 10 000a 0001",
                                  edges, quotient, remainder); end
      @(posedge clk); #1;
   endtask

   initial begin
      test_reset();
      test_directed();
      test_start_ignored();
      test_random();
      test_abort_reset();
      test_back_to_back();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
